reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 98 +++++++++
 tb/tb_reg_scoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard for a 3-stage EX/MEM/WB pipeline; SB_FORWARD_EN selects load-use-only stalling.
// Latency: issue_ready is combinational; an accepted issue is visible in EX one cycle later.
// Backpressure: issue_ready drops on a source hazard; flush kills EX/MEM and the same-cycle issue.
module reg_scoreboard (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [3:0]  issue_Ra,
   input  logic [3:0]  issue_Rb,
   input  logic [3:0]  issue_Rd,
   input  logic [1:0]  issue_opType,
   input  logic [3:0]  issue_opCode,
   input  logic        flush,
   output logic        issue_ready,
   output logic [3:0]  ex_rd,
   output logic [3:0]  mem_rd,
   output logic [3:0]  wb_rd,
   output logic        ex_wr,
   output logic        mem_wr,
   output logic        wb_wr,
   output logic [15:0] busy,
   output logic [15:0] stall_cnt
);

   typedef struct packed {
      logic       wr;
      logic [3:0] rd;
      logic       ld;
   } slotEntry_t;

   localparam slotEntry_t BUBBLE = '{wr: 1'b0, rd: 4'd0, ld: 1'b0};

   slotEntry_t exQ, memQ, wbQ;
   slotEntry_t newSlot;
   logic       isLoad, isWriter, hazard, accept, stallNow;

   function automatic logic hits(input logic [3:0] src, input slotEntry_t s);
      return (src != 4'd0) && s.wr && (s.rd == src);
   endfunction

   always_comb begin
      isLoad      = (issue_opType == 2'b10) && (issue_opCode == 4'b0000);
      isWriter    = !issue_opType[1] || isLoad;
      newSlot.wr  = isWriter && (issue_Rd != 4'd0);
      newSlot.rd  = issue_Rd;
      newSlot.ld  = isLoad;
   end

   always_comb begin
`ifdef SB_FORWARD_EN
      // Everything except a load still sitting in EX can be forwarded.
      hazard = exQ.ld && (hits(issue_Ra, exQ) || hits(issue_Rb, exQ));
`else
      hazard = hits(issue_Ra, exQ) || hits(issue_Ra, memQ) || hits(issue_Ra, wbQ) ||
               hits(issue_Rb, exQ) || hits(issue_Rb, memQ) || hits(issue_Rb, wbQ);
`endif
      issue_ready = !(issue_valid && hazard);
      accept      = issue_valid && issue_ready && !flush;
      stallNow    = issue_valid && !issue_ready && !flush;
   end

   always_comb begin
      busy = 16'h0000;
      if (exQ.wr)  busy[exQ.rd]  = 1'b1;
      if (memQ.wr) busy[memQ.rd] = 1'b1;
      if (wbQ.wr)  busy[wbQ.rd]  = 1'b1;
      busy[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exQ       <= BUBBLE;
         memQ      <= BUBBLE;
         wbQ       <= BUBBLE;
         stall_cnt <= 16'h0000;
      end else begin
         // WB always takes MEM's old content, so a flush never kills a retiring op.
         wbQ <= memQ;
         if (flush) begin
            memQ <= BUBBLE;
            exQ  <= BUBBLE;
         end else begin
            memQ <= exQ;
            exQ  <= accept ? newSlot : BUBBLE;
         end
         if (stallNow && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign ex_rd  = exQ.rd;
   assign ex_wr  = exQ.wr;
   assign mem_rd = memQ.rd;
   assign mem_wr = memQ.wr;
   assign wb_rd  = wbQ.rd;
   assign wb_wr  = wbQ.wr;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: reset, table vectors, hand sequences, randomized model compare, saturation.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issueValid;
   logic [3:0]  issueRa, issueRb, issueRd;
   logic [1:0]  issueOpType;
   logic [3:0]  issueOpCode;
   logic        flush;
   logic        issueReady;
   logic [3:0]  exRd, memRd, wbRd;
   logic        exWr, memWr, wbWr;
   logic [15:0] busy, stallCnt;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk(clk), .rst(rst), .issue_valid(issueValid),
      .issue_Ra(issueRa), .issue_Rb(issueRb), .issue_Rd(issueRd),
      .issue_opType(issueOpType), .issue_opCode(issueOpCode), .flush(flush),
      .issue_ready(issueReady),
      .ex_rd(exRd), .mem_rd(memRd), .wb_rd(wbRd),
      .ex_wr(exWr), .mem_wr(memWr), .wb_wr(wbWr),
      .busy(busy), .stall_cnt(stallCnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic setIn(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic [1:0] ot, input logic [3:0] oc,
                        input logic fl);
      issueValid = v; issueRa = ra; issueRb = rb; issueRd = rd;
      issueOpType = ot; issueOpCode = oc; flush = fl;
   endtask

   // Behavioural model: slot 0 = EX, 1 = MEM, 2 = WB.
   int mWr[3], mRd[3], mLd[3];
   int mStall;

   function automatic bit srcUsesPending(input int src);
      bit r = 0;
      if (src == 0) return 0;
      for (int i = 0; i < 3; i++) begin
`ifdef SB_FORWARD_EN
         if (i == 0 && mWr[i] != 0 && mLd[i] != 0 && mRd[i] == src) r = 1;
`else
         if (mWr[i] != 0 && mRd[i] == src) r = 1;
`endif
      end
      return r;
   endfunction

   function automatic bit modelReady();
      if (!issueValid) return 1;
      return !(srcUsesPending(int'(issueRa)) || srcUsesPending(int'(issueRb)));
   endfunction

   function automatic int modelBusy();
      int b = 0;
      for (int i = 0; i < 3; i++)
         if (mWr[i] != 0 && mRd[i] != 0) b |= (1 << mRd[i]);
      return b;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin mWr[i] = 0; mRd[i] = 0; mLd[i] = 0; end
      mStall = 0;
   endtask

   task automatic modelStep();
      bit rdy = modelReady();
      bit ld  = (issueOpType == 2'b10) && (issueOpCode == 4'd0);
      bit wrt = (issueOpType[1] == 1'b0) || ld;
      if (issueValid && !rdy && !flush && mStall < 65535) mStall++;
      mWr[2] = mWr[1]; mRd[2] = mRd[1]; mLd[2] = mLd[1];
      if (flush) begin
         mWr[1] = 0; mRd[1] = 0; mLd[1] = 0;
         mWr[0] = 0; mRd[0] = 0; mLd[0] = 0;
      end else begin
         mWr[1] = mWr[0]; mRd[1] = mRd[0]; mLd[1] = mLd[0];
         if (issueValid && rdy) begin
            mWr[0] = (wrt && issueRd != 0) ? 1 : 0;
            mRd[0] = int'(issueRd);
            mLd[0] = ld ? 1 : 0;
         end else begin
            mWr[0] = 0; mRd[0] = 0; mLd[0] = 0;
         end
      end
   endtask

   task automatic doReset();
      setIn(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", issueReady, 1);
      chk("reset_busy", busy, 0);
      chk("reset_stall", stallCnt, 0);
      chk("reset_wr", {exWr, memWr, wbWr}, 0);
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic v; logic [3:0] ra, rb, rd; logic [1:0] ot; logic [3:0] oc; logic fl;
      logic eRdy; logic eExWr; logic [3:0] eExRd; logic [15:0] eBusy; logic [15:0] eStall;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] rd, input logic [1:0] ot, input logic [3:0] oc,
                               input logic fl, input logic eRdy, input logic eExWr,
                               input logic [3:0] eExRd, input logic [15:0] eBusy,
                               input logic [15:0] eStall);
      vec_t t;
      t.v = v; t.ra = ra; t.rb = rb; t.rd = rd; t.ot = ot; t.oc = oc; t.fl = fl;
      t.eRdy = eRdy; t.eExWr = eExWr; t.eExRd = eExRd; t.eBusy = eBusy; t.eStall = eStall;
      return t;
   endfunction

   initial begin
      vec_t vecs[12];
      int   satCycles;
      rst = 1'b0;
      setIn(0, 0, 0, 0, 0, 0, 0);
      doReset();
      chk("idle_ready", issueReady, 1);
      chk("idle_busy", busy, 0);

`ifndef SB_FORWARD_EN
      // Post-edge expectations: EX write/rd, busy, stall count after each vector's edge.
      vecs[0]  = mk(0, 0, 0, 0, 2'b00, 4'h0, 0, 1, 0, 0, 16'h0000, 0);
      vecs[1]  = mk(1, 0, 0, 5, 2'b00, 4'h1, 0, 1, 1, 5, 16'h0020, 0);
      vecs[2]  = mk(1, 0, 5, 6, 2'b00, 4'h2, 0, 0, 0, 0, 16'h0020, 1);
      vecs[3]  = mk(1, 0, 5, 6, 2'b00, 4'h2, 0, 0, 0, 0, 16'h0020, 2);
      vecs[4]  = mk(1, 0, 5, 6, 2'b00, 4'h2, 0, 0, 0, 0, 16'h0000, 3);
      vecs[5]  = mk(1, 0, 5, 6, 2'b00, 4'h2, 0, 1, 1, 6, 16'h0040, 3);
      vecs[6]  = mk(1, 0, 0, 0, 2'b01, 4'h3, 0, 1, 0, 0, 16'h0040, 3);
      vecs[7]  = mk(1, 0, 0, 0, 2'b11, 4'h4, 0, 1, 0, 0, 16'h0040, 3);
      vecs[8]  = mk(1, 0, 0, 0, 2'b10, 4'h1, 0, 1, 0, 0, 16'h0000, 3);
      vecs[9]  = mk(1, 0, 0, 3, 2'b10, 4'h0, 0, 1, 1, 3, 16'h0008, 3);
      vecs[10] = mk(1, 3, 0, 4, 2'b00, 4'h5, 1, 0, 0, 0, 16'h0000, 3);
      vecs[11] = mk(1, 3, 0, 4, 2'b00, 4'h5, 0, 1, 1, 4, 16'h0010, 3);
      for (int i = 0; i < 12; i++) begin
         setIn(vecs[i].v, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].ot, vecs[i].oc, vecs[i].fl);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), issueReady, vecs[i].eRdy);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_exwr", i), exWr, vecs[i].eExWr);
         if (vecs[i].eExWr) chk($sformatf("vec%0d_exrd", i), exRd, vecs[i].eExRd);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].eBusy);
         chk($sformatf("vec%0d_stall", i), stallCnt, vecs[i].eStall);
      end
`else
      // Load R3 then a consumer of R3: exactly one load-use stall.
      setIn(1, 0, 0, 3, 2'b10, 4'h0, 0);
      @(negedge clk); chk("lu_load_ready", issueReady, 1);
      @(posedge clk); #1;
      setIn(1, 3, 0, 4, 2'b00, 4'h1, 0);
      @(negedge clk); chk("lu_stall_ready", issueReady, 0);
      @(posedge clk); #1;
      @(negedge clk); chk("lu_accept_ready", issueReady, 1);
      chk("lu_stall_cnt", stallCnt, 1);
      @(posedge clk); #1;
      chk("lu_ex_wr", exWr, 1);
      chk("lu_ex_rd", exRd, 4);
`endif

      // Writer Rd=0 then consumer of R0: never a hazard, nothing marked busy.
      doReset();
      setIn(1, 0, 0, 0, 2'b00, 4'h1, 0);
      @(posedge clk); #1;
      setIn(1, 0, 0, 0, 2'b00, 4'h2, 0);
      @(negedge clk); chk("r0_ready", issueReady, 1);
      chk("r0_exwr", exWr, 0);
      chk("r0_busy", busy, 0);
      @(posedge clk); #1;

      // Flush with R1 in EX, R2 in MEM and R4 issuing.
      doReset();
      setIn(1, 0, 0, 2, 2'b00, 4'h1, 0);
      @(posedge clk); #1;
      setIn(1, 0, 0, 1, 2'b00, 4'h1, 0);
      @(posedge clk); #1;
      chk("fl_pre_busy", busy, 16'h0006);
      setIn(1, 0, 0, 4, 2'b00, 4'h1, 1);
      @(posedge clk); #1;
      setIn(0, 0, 0, 0, 2'b00, 4'h0, 0);
      chk("fl_exwr", exWr, 0);
      chk("fl_memwr", memWr, 0);
      chk("fl_wbwr", wbWr, 1);
      chk("fl_wbrd", wbRd, 2);
      chk("fl_busy", busy, 16'h0004);
      chk("fl_stall", stallCnt, 0);

      // Asynchronous reset in the middle of a cycle with work in flight.
      setIn(1, 0, 0, 7, 2'b00, 4'h1, 0);
      @(posedge clk); #1;
      setIn(0, 0, 0, 0, 2'b00, 4'h0, 0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wr", {exWr, memWr, wbWr}, 0);
      chk("mid_rst_ready", issueReady, 1);
      @(negedge clk); rst = 1'b1;
      modelReset();
      @(posedge clk); #1;

      // Randomized traffic against the model; small register range to provoke hazards.
      for (int c = 0; c < 3000; c++) begin
         setIn(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
               4'($urandom_range(0, 4)), 2'($urandom), 4'($urandom_range(0, 2)),
               ($urandom_range(0, 9) == 0));
         @(negedge clk);
         chk("rnd_ready", issueReady, modelReady());
         chk("rnd_busy", busy, modelBusy());
         chk("rnd_stall", stallCnt, mStall);
         chk("rnd_wr", {exWr, memWr, wbWr}, {mWr[0][0], mWr[1][0], mWr[2][0]});
         if (mWr[0] != 0) chk("rnd_exrd", exRd, mRd[0]);
         if (mWr[1] != 0) chk("rnd_memrd", memRd, mRd[1]);
         if (mWr[2] != 0) chk("rnd_wbrd", wbRd, mRd[2]);
         @(posedge clk);
         modelStep();
         #1;
      end

      // Self-dependent load issued continuously keeps re-creating its own hazard.
      doReset();
`ifdef SB_FORWARD_EN
      satCycles = 132000;
`else
      satCycles = 88000;
`endif
      setIn(1, 5, 0, 5, 2'b10, 4'h0, 0);
      repeat (satCycles) @(posedge clk);
      #1;
      chk("sat_stall_cnt", stallCnt, 16'hFFFF);
      setIn(0, 0, 0, 0, 2'b00, 4'h0, 0);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
